// File: rtl/dmem_pkg.sv
// Shared types and byte-lane helpers for the data memory responder.
package dmem_pkg;

    localparam int LANES = 8;

    typedef enum logic [3:0] {
        SZ_B  = 4'd0,
        SZ_H  = 4'd1,
        SZ_W  = 4'd2,
        SZ_D  = 4'd3,
        SZ_WU = 4'd4,
        SZ_HU = 4'd5,
        SZ_BU = 4'd6
    } mem_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_RESP,
        ST_WR_COMMIT,
        ST_WR_DONE
    } dmem_state_e;

    function automatic logic [3:0] size_bytes(input logic [3:0] size);
        case (size)
            SZ_B, SZ_BU: size_bytes = 4'd1;
            SZ_H, SZ_HU: size_bytes = 4'd2;
            SZ_W, SZ_WU: size_bytes = 4'd4;
            SZ_D:        size_bytes = 4'd8;
            default:     size_bytes = 4'd0;
        endcase
    endfunction

    // Bits shifted past lane 7 fall off the top, which clips a boundary-crossing access.
    function automatic logic [LANES-1:0] lane_mask(input logic [3:0] size, input logic [2:0] lane);
        logic [15:0] base;
        logic [15:0] shifted;
        base    = (16'd1 << size_bytes(size)) - 16'd1;
        shifted = base << lane;
        return shifted[LANES-1:0];
    endfunction

    function automatic logic crosses_word(input logic [3:0] size, input logic [2:0] lane);
        return ({1'b0, lane} + size_bytes(size)) > 4'd8;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-enable and lane shifter for stores and loads.
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [3:0]            size_i,
    input  logic [2:0]            lane_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rword_i,
    output logic [LANES-1:0]      be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  misalign_o
);

    assign be_o       = lane_mask(size_i, lane_i);
    assign wdata_o    = wdata_i << {lane_i, 3'b000};
    assign rdata_o    = rword_i >> {lane_i, 3'b000};
    assign misalign_o = crosses_word(size_i, lane_i);

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a word-addressed local array.
// Optional macro DMEM_MISALIGN_CHECK_EN adds misalign_err and suppresses misaligned stores.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int MEM_WORDS    = 4096,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] S_R_ADDR,
    input  logic                  S_R_ADDR_VALID,
    output logic [DATA_WIDTH-1:0] S_R_DATA,
    output logic                  S_R_DATA_VALID,
    input  logic                  S_W_VALID,
    input  logic [ADDR_WIDTH-1:0] S_W_ADDR,
    input  logic [DATA_WIDTH-1:0] S_W_DATA,
    input  logic [3:0]            S_W_SIZE,
    output logic                  S_W_READY,
    output logic                  S_W_COMPLETE
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    output logic                  misalign_err
`endif
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    dmem_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            size_q, size_d;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_valid_q, w_complete_q, w_ready_q;

    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [IDX_W-1:0]      acc_idx;
    logic [3:0]            acc_size;
    logic [DATA_WIDTH-1:0] acc_word, wdata_lane, rdata_lane;
    logic [LANES-1:0]      be_raw, be;
    logic                  misaligned;

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    // A latency-1 load reads the array on the capture edge, so it uses the live address.
    assign acc_addr = (state_q == ST_IDLE) ? S_R_ADDR : addr_q;
    assign acc_idx  = acc_addr[3 +: IDX_W];
    assign acc_size = (state_q == ST_WR_COMMIT) ? size_q : 4'(SZ_D);
    assign acc_word = mem_q[acc_idx];

    dmem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .size_i     (acc_size),
        .lane_i     (acc_addr[2:0]),
        .wdata_i    (wdata_q),
        .rword_i    (acc_word),
        .be_o       (be_raw),
        .wdata_o    (wdata_lane),
        .rdata_o    (rdata_lane),
        .misalign_o (misaligned)
    );

`ifdef DMEM_MISALIGN_CHECK_EN
    assign be = misaligned ? '0 : be_raw;
    logic unused_hi;
    assign unused_hi = ^acc_addr[ADDR_WIDTH-1:IDX_W+3];
`else
    assign be = be_raw;
    logic unused_hi;
    assign unused_hi = ^{acc_addr[ADDR_WIDTH-1:IDX_W+3], misaligned};
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        unique case (state_q)
            ST_IDLE: begin
                if (S_R_ADDR_VALID) begin
                    addr_d  = S_R_ADDR;
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                    state_d = (READ_LATENCY == 1) ? ST_RD_RESP : ST_RD_WAIT;
                end else if (S_W_VALID && w_ready_q) begin
                    addr_d  = S_W_ADDR;
                    wdata_d = S_W_DATA;
                    size_d  = S_W_SIZE;
                    state_d = ST_WR_COMMIT;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) state_d = ST_RD_RESP;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_RD_RESP:   state_d = ST_IDLE;
            ST_WR_COMMIT: state_d = ST_WR_DONE;
            ST_WR_DONE:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            r_data_q     <= '0;
            r_valid_q    <= 1'b0;
            w_complete_q <= 1'b0;
            w_ready_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            r_valid_q    <= (state_d == ST_RD_RESP);
            w_complete_q <= (state_d == ST_WR_DONE);
            w_ready_q    <= (state_d == ST_IDLE);
            if (state_d == ST_RD_RESP) r_data_q <= rdata_lane;
        end
    end

    // NOTE: the array is deliberately not reset; only the control path is, and a reset blocks the commit.
    always_ff @(posedge clk) begin
        if (reset && state_q == ST_WR_COMMIT) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) mem_q[acc_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    logic misalign_q;
    always_ff @(posedge clk) begin
        if (!reset) misalign_q <= 1'b0;
        else        misalign_q <= misaligned && (state_d == ST_RD_RESP || state_d == ST_WR_DONE);
    end
    assign misalign_err = misalign_q;
`endif

    assign S_R_DATA       = r_data_q;
    assign S_R_DATA_VALID = r_valid_q;
    assign S_W_READY      = w_ready_q;
    assign S_W_COMPLETE   = w_complete_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder (default parameters, READ_LATENCY=2).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] S_R_ADDR = '0;
    logic        S_R_ADDR_VALID = 1'b0;
    logic [63:0] S_R_DATA;
    logic        S_R_DATA_VALID;
    logic        S_W_VALID = 1'b0;
    logic [63:0] S_W_ADDR = '0;
    logic [63:0] S_W_DATA = '0;
    logic [3:0]  S_W_SIZE = '0;
    logic        S_W_READY;
    logic        S_W_COMPLETE;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .S_R_ADDR       (S_R_ADDR),
        .S_R_ADDR_VALID (S_R_ADDR_VALID),
        .S_R_DATA       (S_R_DATA),
        .S_R_DATA_VALID (S_R_DATA_VALID),
        .S_W_VALID      (S_W_VALID),
        .S_W_ADDR       (S_W_ADDR),
        .S_W_DATA       (S_W_DATA),
        .S_W_SIZE       (S_W_SIZE),
        .S_W_READY      (S_W_READY),
        .S_W_COMPLETE   (S_W_COMPLETE)
`ifdef DMEM_MISALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic [63:0] EXP_W100 = 64'h1122_3344_AB66_7788;
    localparam logic [63:0] EXP_W105 = 64'h0000_0000_0011_2233;
`else
    localparam logic [63:0] EXP_W100 = 64'hBEEF_3344_AB66_7788;
    localparam logic [63:0] EXP_W105 = 64'h0000_0000_00BE_EF33;
`endif

    typedef struct {
        logic        is_store;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  size;
        logic [63:0] exp_rdata;
        logic        exp_mis;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic cur_mis();
`ifdef DMEM_MISALIGN_CHECK_EN
        return misalign_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic add_st(input string name, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [3:0] size, input logic mis);
        vecs.push_back('{1'b1, addr, wdata, size, 64'd0, mis, name});
    endtask

    task automatic add_ld(input string name, input logic [63:0] addr, input logic [63:0] exp, input logic mis);
        vecs.push_back('{1'b0, addr, 64'd0, 4'd0, exp, mis, name});
    endtask

    // Called at a negedge with the DUT idle; returns capture-to-valid cycles (0 on timeout).
    task automatic do_load(input logic [63:0] addr, output logic [63:0] data, output int lat,
                           output logic saw_ready, output logic mis, output logic tail, output logic held);
        S_R_ADDR = addr;
        S_R_ADDR_VALID = 1'b1;
        lat = 0; saw_ready = 1'b0; mis = 1'b0; data = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (S_R_DATA_VALID) begin
                lat = k; data = S_R_DATA; mis = cur_mis();
                break;
            end
            if (S_W_READY) saw_ready = 1'b1;
        end
        S_R_ADDR_VALID = 1'b0;
        @(negedge clk);
        tail = S_R_DATA_VALID;
        held = (S_R_DATA === data);
    endtask

    task automatic do_store(input logic [63:0] addr, input logic [63:0] wdata, input logic [3:0] size,
                            output int lat, output logic saw_ready, output logic mis, output logic tail);
        S_W_ADDR = addr; S_W_DATA = wdata; S_W_SIZE = size;
        S_W_VALID = 1'b1;
        lat = 0; saw_ready = 1'b0; mis = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            S_W_VALID = 1'b0;
            if (S_W_COMPLETE) begin
                lat = k; mis = cur_mis();
                break;
            end
            if (S_W_READY) saw_ready = 1'b1;
        end
        S_W_VALID = 1'b0;
        @(negedge clk);
        tail = S_W_COMPLETE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] data;
        int          lat, rd_k, wr_k;
        logic        saw_ready, mis, tail, held, seen_bad;

        add_st("st_d_100",   64'h100, 64'h1122_3344_5566_7788, 4'd3, 1'b0);
        add_ld("ld_d_100",   64'h100, 64'h1122_3344_5566_7788, 1'b0);
        add_st("st_b_103",   64'h103, 64'hCCCC_CCCC_CCCC_CCAB, 4'd0, 1'b0);
        add_ld("ld_merge",   64'h100, 64'h1122_3344_AB66_7788, 1'b0);
        add_ld("ld_103",     64'h103, 64'h0000_0011_2233_44AB, 1'b1);
        add_st("st_d_200",   64'h200, 64'h0,                   4'd3, 1'b0);
        add_st("st_hu_202",  64'h202, 64'h0000_0000_0000_CAFE, 4'd5, 1'b0);
        add_st("st_wu_204",  64'h204, 64'h0000_0000_1234_5678, 4'd4, 1'b0);
        add_st("st_bu_200",  64'h200, 64'h0000_0000_0000_005A, 4'd6, 1'b0);
        add_st("st_h_206",   64'h206, 64'h0000_0000_0000_9911, 4'd1, 1'b0);
        add_st("st_bad7",    64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 4'd7, 1'b0);
        add_st("st_bad15",   64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 4'd15, 1'b0);
        add_ld("ld_200",     64'h200, 64'h9911_5678_CAFE_005A, 1'b0);
        add_ld("ld_201",     64'h201, 64'h0099_1156_78CA_FE00, 1'b1);
        add_ld("ld_wrap",    64'h8200, 64'h9911_5678_CAFE_005A, 1'b0);
        add_ld("ld_wrap_hi", 64'h8000_0000_0000_0200, 64'h9911_5678_CAFE_005A, 1'b0);
        add_st("st_w_106",   64'h106, 64'h0000_0000_DEAD_BEEF, 4'd2, 1'b1);
        add_ld("ld_after_mis", 64'h100, EXP_W100, 1'b0);
        add_ld("ld_105",     64'h105, EXP_W105, 1'b1);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_r_valid",    64'(S_R_DATA_VALID), 64'd0);
        check("rst_w_complete", 64'(S_W_COMPLETE),   64'd0);
        check("rst_w_ready",    64'(S_W_READY),      64'd0);
        check("rst_r_data",     S_R_DATA,            64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_w_ready",   64'(S_W_READY),      64'd1);

        foreach (vecs[i]) begin
            if (vecs[i].is_store) begin
                do_store(vecs[i].addr, vecs[i].wdata, vecs[i].size, lat, saw_ready, mis, tail);
                check({vecs[i].name, "_latency"},  64'(lat),       64'd2);
                check({vecs[i].name, "_busy_rdy"}, 64'(saw_ready), 64'd0);
                check({vecs[i].name, "_pulse"},    64'(tail),      64'd0);
            end else begin
                do_load(vecs[i].addr, data, lat, saw_ready, mis, tail, held);
                check({vecs[i].name, "_data"},     data,           vecs[i].exp_rdata);
                check({vecs[i].name, "_latency"},  64'(lat),       64'd3);
                check({vecs[i].name, "_busy_rdy"}, 64'(saw_ready), 64'd0);
                check({vecs[i].name, "_pulse"},    64'(tail),      64'd0);
                check({vecs[i].name, "_hold"},     64'(held),      64'd1);
            end
`ifdef DMEM_MISALIGN_CHECK_EN
            check({vecs[i].name, "_mis"}, 64'(mis), 64'(vecs[i].exp_mis));
`endif
        end

        // Read and store presented together: read first, store later, nothing lost
        S_R_ADDR = 64'h100; S_R_ADDR_VALID = 1'b1;
        S_W_ADDR = 64'h100; S_W_DATA = 64'h0102_0304_0506_0708; S_W_SIZE = 4'd3; S_W_VALID = 1'b1;
        rd_k = 0; wr_k = 0; data = '0;
        for (int k = 1; k <= 20 && wr_k == 0; k++) begin
            @(negedge clk);
            if (S_R_DATA_VALID && rd_k == 0) begin
                rd_k = k; data = S_R_DATA; S_R_ADDR_VALID = 1'b0;
            end
            if (S_W_COMPLETE) begin
                wr_k = k; S_W_VALID = 1'b0;
            end
        end
        S_R_ADDR_VALID = 1'b0; S_W_VALID = 1'b0;
        @(negedge clk);
        check("both_rd_latency", 64'(rd_k), 64'd3);
        check("both_rd_data",    data,      EXP_W100);
        check("both_wr_cycle",   64'(wr_k), 64'd6);
        do_load(64'h100, data, lat, saw_ready, mis, tail, held);
        check("both_wr_result",  data,      64'h0102_0304_0506_0708);

        // Reset during RD_WAIT aborts the load
        S_R_ADDR = 64'h200; S_R_ADDR_VALID = 1'b1;
        @(negedge clk);
        reset = 1'b0; S_R_ADDR_VALID = 1'b0;
        @(negedge clk);
        check("abort_rd_rst_ready", 64'(S_W_READY), 64'd0);
        reset = 1'b1;
        seen_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (S_R_DATA_VALID) seen_bad = 1'b1;
        end
        check("abort_rd_no_valid", 64'(seen_bad),  64'd0);
        check("abort_rd_idle",     64'(S_W_READY), 64'd1);

        // Reset during WR_COMMIT aborts the store without writing
        S_W_ADDR = 64'h200; S_W_DATA = 64'h0; S_W_SIZE = 4'd3; S_W_VALID = 1'b1;
        @(negedge clk);
        reset = 1'b0; S_W_VALID = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        seen_bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (S_W_COMPLETE) seen_bad = 1'b1;
        end
        check("abort_wr_no_complete", 64'(seen_bad), 64'd0);
        do_load(64'h200, data, lat, saw_ready, mis, tail, held);
        check("abort_contents", data, 64'h9911_5678_CAFE_005A);
        check("abort_ld_latency", 64'(lat), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
